// File: rtl/vm_pkg.sv
// Shared vending-machine definitions: coin encodings, coin values,
// dispenser FSM states and the default stock level.
package vm_pkg;

  localparam logic [3:0] COIN_NONE = 4'b0000;
  localparam logic [3:0] COIN_1    = 4'b0001;
  localparam logic [3:0] COIN_2    = 4'b0010;
  localparam logic [3:0] COIN_5    = 4'b0100;
  localparam logic [3:0] COIN_10   = 4'b1000;

  localparam logic [3:0] COIN_VAL_1  = 4'd1;
  localparam logic [3:0] COIN_VAL_2  = 4'd2;
  localparam logic [3:0] COIN_VAL_5  = 4'd5;
  localparam logic [3:0] COIN_VAL_10 = 4'd10;

  localparam int STOCK_INIT_DEFAULT = 5;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SELECT,
    ST_DROP,
    ST_WAIT_ACK,
    ST_FINISH
  } vm_state_e;

  // Value in units of a one-hot coin code; anything not one-hot is worth 0.
  function automatic logic [3:0] coin_value(input logic [3:0] onehot);
    logic [3:0] val;
    case (onehot)
      COIN_1:  val = COIN_VAL_1;
      COIN_2:  val = COIN_VAL_2;
      COIN_5:  val = COIN_VAL_5;
      COIN_10: val = COIN_VAL_10;
      default: val = 4'd0;
    endcase
    return val;
  endfunction

endpackage

// File: rtl/coin_select.sv
// Greedy coin picker: largest coin that fits the remaining amount and is
// still in stock. No backtracking, so some amounts end up short.
module coin_select
  import vm_pkg::*;
(
  input  logic [3:0] remaining_i,
  input  logic [3:0] stock_empty_i,
  output logic [3:0] sel_o,
  output logic       none_o
);

  // Priority from the 10 down to the 1; remaining 0 naturally selects nothing.
  always_comb begin
    sel_o  = COIN_NONE;
    none_o = 1'b0;
    if (!stock_empty_i[3] && (remaining_i >= COIN_VAL_10)) begin
      sel_o = COIN_10;
    end else if (!stock_empty_i[2] && (remaining_i >= COIN_VAL_5)) begin
      sel_o = COIN_5;
    end else if (!stock_empty_i[1] && (remaining_i >= COIN_VAL_2)) begin
      sel_o = COIN_2;
    end else if (!stock_empty_i[0] && (remaining_i >= COIN_VAL_1)) begin
      sel_o = COIN_1;
    end else begin
      none_o = 1'b1;
    end
  end

endmodule

// File: rtl/change_dispenser.sv
// Change dispenser: pays out a requested amount one coin at a time using
// greedy selection, waits for the hopper to confirm each drop, tracks
// per-denomination stock and flags jams and short payouts.
module change_dispenser
  import vm_pkg::*;
#(
  parameter int STOCK_INIT   = STOCK_INIT_DEFAULT,
  parameter int PULSE_CYCLES = 2,
  parameter int ACK_TIMEOUT  = 15
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       req_valid,
  input  logic [3:0] req_amount,
  output logic       req_ready,
  input  logic       refill,
  input  logic       hopper_ack,
  output logic [3:0] coin_out,
  output logic       busy,
  output logic       done,
  output logic [3:0] short_amount,
  output logic       short_led,
  output logic [3:0] stock_empty,
  output logic       jam
);

  localparam logic [2:0] STOCK_RST  = 3'(STOCK_INIT);
  localparam logic [3:0] PULSE_LAST = 4'(PULSE_CYCLES - 1);
  localparam logic [7:0] WAIT_LAST  = 8'(ACK_TIMEOUT - 1);

  vm_state_e  state_q, state_d;
  logic [3:0] remaining_q, remaining_d;
  logic [3:0] sel_q, sel_d;
  logic [3:0] pulse_q, pulse_d;
  logic [7:0] wait_q, wait_d;
  logic [2:0] stock_q [4];
  logic [2:0] stock_d [4];
  logic       jam_q, jam_d;
  logic [3:0] short_q, short_d;
  logic       short_led_q, short_led_d;

  logic       accept;
  logic       ack_take;
  logic       timeout;
  logic [3:0] empty_w;
  logic [3:0] pick_sel;
  logic       pick_none;

  // Handshake and WAIT_ACK event decode; an ack beats a simultaneous timeout.
  always_comb begin
    accept   = (state_q == ST_IDLE) && req_valid;
    ack_take = (state_q == ST_WAIT_ACK) && hopper_ack;
    timeout  = (state_q == ST_WAIT_ACK) && !hopper_ack && (wait_q == WAIT_LAST);
    for (int i = 0; i < 4; i++) begin
      empty_w[i] = (stock_q[i] == 3'd0);
    end
  end

  coin_select u_coin_select (
    .remaining_i  (remaining_q),
    .stock_empty_i(empty_w),
    .sel_o        (pick_sel),
    .none_o       (pick_none)
  );

  // State register; reset aborts any request in flight.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:     if (accept) state_d = ST_SELECT;
      ST_SELECT:   state_d = pick_none ? ST_FINISH : ST_DROP;
      ST_DROP:     if (pulse_q == PULSE_LAST) state_d = ST_WAIT_ACK;
      ST_WAIT_ACK: if (ack_take || timeout) state_d = ST_SELECT;
      ST_FINISH:   state_d = ST_IDLE;
      default:     state_d = ST_IDLE;
    endcase
  end

  // Datapath next values. The short result is captured when SELECT gives up,
  // so it is already valid during the FINISH cycle that raises done.
  always_comb begin
    remaining_d = remaining_q;
    sel_d       = sel_q;
    pulse_d     = pulse_q;
    wait_d      = wait_q;
    stock_d     = stock_q;
    jam_d       = jam_q;
    short_d     = short_q;
    short_led_d = short_led_q;
    case (state_q)
      ST_IDLE: begin
        if (refill) begin
          for (int i = 0; i < 4; i++) stock_d[i] = STOCK_RST;
          jam_d = 1'b0;
        end
        if (accept) begin
          remaining_d = req_amount;
          short_d     = 4'd0;
          short_led_d = 1'b0;
        end
      end
      ST_SELECT: begin
        sel_d   = pick_sel;
        pulse_d = 4'd0;
        if (pick_none) begin
          short_d     = remaining_q;
          short_led_d = (remaining_q != 4'd0);
        end
      end
      ST_DROP: begin
        pulse_d = pulse_q + 4'd1;
        wait_d  = 8'd0;
      end
      ST_WAIT_ACK: begin
        wait_d = wait_q + 8'd1;
        if (ack_take) begin
          remaining_d = remaining_q - coin_value(sel_q);
          for (int i = 0; i < 4; i++) begin
            if (sel_q[i] && (stock_q[i] != 3'd0)) stock_d[i] = stock_q[i] - 3'd1;
          end
        end else if (timeout) begin
          for (int i = 0; i < 4; i++) begin
            if (sel_q[i]) stock_d[i] = 3'd0;
          end
          jam_d = 1'b1;
        end
      end
      default: begin
      end
    endcase
  end

  // Datapath registers.
  always_ff @(posedge clk) begin
    if (!reset) begin
      remaining_q <= 4'd0;
      sel_q       <= COIN_NONE;
      pulse_q     <= 4'd0;
      wait_q      <= 8'd0;
      for (int i = 0; i < 4; i++) stock_q[i] <= STOCK_RST;
      jam_q       <= 1'b0;
      short_q     <= 4'd0;
      short_led_q <= 1'b0;
    end else begin
      remaining_q <= remaining_d;
      sel_q       <= sel_d;
      pulse_q     <= pulse_d;
      wait_q      <= wait_d;
      stock_q     <= stock_d;
      jam_q       <= jam_d;
      short_q     <= short_d;
      short_led_q <= short_led_d;
    end
  end

  // Outputs decoded from state and registers.
  always_comb begin
    req_ready    = (state_q == ST_IDLE) && reset;
    busy         = (state_q != ST_IDLE);
    done         = (state_q == ST_FINISH);
    coin_out     = (state_q == ST_DROP) ? sel_q : COIN_NONE;
    short_amount = short_q;
    short_led    = short_led_q;
    stock_empty  = empty_w;
    jam          = jam_q;
  end

endmodule

// File: doc/change_dispenser.md
CHANGE_DISPENSER -- requirements
Module: change_dispenser

Interface
REQ-001 Parameter STOCK_INIT, default 5, coins per denomination after reset or refill (3-bit counters, range 0..7).
REQ-002 Parameter PULSE_CYCLES, default 2, cycles coin_out is held per coin (1..15).
REQ-003 Parameter ACK_TIMEOUT, default 15, WAIT_ACK cycles before a jam is declared (1..255).
REQ-004 clk  in  1  single clock; all logic on posedge.
REQ-005 reset  in  1  synchronous, active-low reset.
REQ-006 req_valid  in  1  change request present.
REQ-007 req_amount  in  4  change to dispense, 0..15 units.
REQ-008 req_ready  out  1  high only in IDLE; request accepted on req_valid && req_ready.
REQ-009 refill  in  1  restore all stock counters to STOCK_INIT.
REQ-010 hopper_ack  in  1  single-cycle pulse from mechanism confirming a coin dropped.
REQ-011 coin_out  out  4  one-hot coin drive: 0001=1, 0010=2, 0100=5, 1000=10; 0000 otherwise.
REQ-012 busy  out  1  high in every state except IDLE.
REQ-013 done  out  1  one-cycle pulse at end of each accepted request.
REQ-014 short_amount  out  4  undispensed remainder, valid while done=1, held until next accept.
REQ-015 short_led  out  1  set with done when short_amount>0; cleared on next accept.
REQ-016 stock_empty  out  4  per denomination (same bit order as coin_out), high when its counter is 0.
REQ-017 jam  out  1  sticky; set on any ack timeout; cleared by refill or reset.

Function
REQ-018 FSM states: IDLE, SELECT, DROP, WAIT_ACK, FINISH.
REQ-019 IDLE: on accept, remaining <= req_amount, short_led <= 0, next SELECT.
REQ-020 SELECT (one cycle): pick largest d in {10,5,2,1} with d <= remaining and stock[d] > 0; found -> latch sel, DROP; none or remaining==0 -> FINISH.
REQ-021 Greedy only, no backtracking (remaining 8, stock of 2s and 1s zero -> dispense 5, short 3).
REQ-022 DROP: coin_out = sel for exactly PULSE_CYCLES cycles, then WAIT_ACK with coin_out = 0.
REQ-023 WAIT_ACK: on hopper_ack, remaining -= value(sel), stock[sel] -= 1, next SELECT.
REQ-024 WAIT_ACK timeout: ACK_TIMEOUT cycles without ack -> stock[sel] <= 0, jam <= 1, remaining unchanged, next SELECT.
REQ-025 hopper_ack and timeout in same cycle: ack wins, no jam.
REQ-026 hopper_ack outside WAIT_ACK ignored.
REQ-027 FINISH: done=1 one cycle, short_amount <= remaining, short_led <= (remaining != 0), next IDLE.
REQ-028 Latency: accept at edge E0 -> SELECT cycle 1 -> coin_out high cycles 2..1+PULSE_CYCLES; req_amount 0 -> done in cycle 2.
REQ-029 refill sampled only in IDLE; ignored elsewhere; refill and accept in same cycle both take effect, SELECT sees refilled stock.
REQ-030 req_valid while busy ignored; req_amount sampled only at accept.
REQ-031 Stock counters never underflow; decrement only on ack with stock>0.

Reset
REQ-032 reset low at a clock edge: state IDLE, stock all STOCK_INIT, remaining 0, all counters 0.
REQ-033 Output reset values: coin_out 0, busy 0, done 0, short_amount 0, short_led 0, jam 0, stock_empty 0; req_ready 0 while reset low, 1 first cycle after release.
REQ-034 Reset mid-operation aborts the request: coin_out 0 next cycle, no done pulse, remaining discarded.

Structure
REQ-035 Shared package vm_pkg holds coin one-hot encodings, coin values (1,2,5,10), FSM state enum and STOCK_INIT default; used by the coin acceptor too.
REQ-036 Greedy picker is one combinational sub-module coin_select (inputs remaining, stock_empty; output one-hot sel, none flag).

Verification
REQ-037 Full stock, amount 13 -> coin_out 1000, 0010, 0001 in order, 3 acks, done, short_amount 0, stock(1,2,5,10)=(4,4,5,4).
REQ-038 Drain 10s (five 10-requests), then amount 15 -> stock_empty=1000, coins 5,5,5, short_amount 0.
REQ-039 1s and 2s drained, amount 9 -> one 5 dispensed, short_amount 4, short_led 1.
REQ-040 Amount 10, ack withheld ACK_TIMEOUT cycles -> jam 1, stock_empty[3]=1, then 5,5 acked, short_amount 0.
REQ-041 reset low during WAIT_ACK -> coin_out 0, no done, req_ready 1 after release, stock all 5.
REQ-042 Amount 0 -> no coin_out activity, done in cycle 2, short_amount 0, short_led 0.
